fp_mul_seq: RTL and testbench

//  Iterative IEEE-754 floating-point multiplier: the multiply counterpart to the FPU's divide path.

---
 rtl/fp_mul_seq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_fp_mul_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: iterative IEEE-754 multiplier (radix-2 shift-add, round to nearest even).
// One operation in flight. Subnormal inputs and results are flushed to signed zero.
// Optional build macro FPMUL_FLAGS_EN adds the fflags[4:0] = {NV,DZ,OF,UF,NX} output.
//
// Handshake: an input transfer happens on a rising edge where in_valid && in_ready;
// an output transfer happens on a rising edge where out_valid && out_ready. Once
// out_valid is high, out (and fflags) stay stable until the output transfer.
// in_ready is high only in IDLE, so an input transfer can never share a cycle
// with an output transfer.
module fp_mul_seq #(
   parameter int BUS_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BUS_WIDTH-1:0] in1,
   input  logic [BUS_WIDTH-1:0] in2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BUS_WIDTH-1:0] out
`ifdef FPMUL_FLAGS_EN
   ,
   output logic [4:0]           fflags
`endif
);

   localparam int EXPONENT_SIZE = (BUS_WIDTH == 64) ? 11 : 8;
   localparam int MANTISSA_SIZE = (BUS_WIDTH == 64) ? 52 : 23;
   localparam int BIAS          = (BUS_WIDTH == 64) ? 1023 : 127;
   localparam int EW            = EXPONENT_SIZE + 2;   // signed working exponent
   localparam int MW            = MANTISSA_SIZE + 1;   // significand with hidden bit
   localparam int PW            = 2 * MW;              // full product width
   localparam int CW            = $clog2(MW);

   localparam logic signed [EW-1:0] BIAS_S  = EW'(BIAS);
   localparam logic signed [EW-1:0] ONE_S   = EW'(1);
   localparam logic signed [EW-1:0] ZERO_S  = EW'(0);
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXPONENT_SIZE) - 1);
   localparam logic [CW-1:0]        LAST_COUNT = CW'(MANTISSA_SIZE);

   localparam logic [BUS_WIDTH-1:0] QNAN =
      {1'b0, {EXPONENT_SIZE{1'b1}}, 1'b1, {(MANTISSA_SIZE-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   // operand fields
   logic                     sign1, sign2;
   logic [EXPONENT_SIZE-1:0] exp1, exp2;
   logic [MANTISSA_SIZE-1:0] man1, man2;
   logic                     nan1, nan2, inf1, inf2, zero1, zero2;
   logic                     inf_times_zero;
   logic                     is_special;
   logic [BUS_WIDTH-1:0]     spec_result;
   logic                     spec_nv;
   logic signed [EW-1:0]     exp_sum;

   // datapath registers
   logic                     sign_q;
   logic signed [EW-1:0]     exp_q;
   logic [PW-1:0]            mcand_q;
   logic [PW-1:0]            acc_q;
   logic [MW-1:0]            mplier_q;
   logic [CW-1:0]            count_q;
   logic [BUS_WIDTH-1:0]     out_q;

   // normalisation / rounding
   logic                     prod_hi;
   logic [MW-1:0]            mant;
   logic                     guard;
   logic                     sticky;
   logic                     round_inc;
   logic [MW:0]              rounded;
   logic [MANTISSA_SIZE-1:0] frac;
   logic signed [EW-1:0]     exp_n;
   logic signed [EW-1:0]     exp_f;
   logic                     ovf;
   logic                     unf;
   logic [BUS_WIDTH-1:0]     norm_result;

`ifdef FPMUL_FLAGS_EN
   logic [4:0]               fflags_q;
   logic                     snan1, snan2;
`endif

   // split operands into fields and classify them
   always_comb begin
      sign1 = in1[BUS_WIDTH-1];
      sign2 = in2[BUS_WIDTH-1];
      exp1  = in1[BUS_WIDTH-2 -: EXPONENT_SIZE];
      exp2  = in2[BUS_WIDTH-2 -: EXPONENT_SIZE];
      man1  = in1[MANTISSA_SIZE-1:0];
      man2  = in2[MANTISSA_SIZE-1:0];
      nan1  = (&exp1) && (|man1);
      nan2  = (&exp2) && (|man2);
      inf1  = (&exp1) && !(|man1);
      inf2  = (&exp2) && !(|man2);
      // exponent 0 covers both true zeros and subnormals (flushed)
      zero1 = !(|exp1);
      zero2 = !(|exp2);
      inf_times_zero = (inf1 && zero2) || (inf2 && zero1);
      is_special = nan1 || nan2 || inf1 || inf2 || zero1 || zero2;
      exp_sum = $signed({2'b00, exp1}) + $signed({2'b00, exp2}) - BIAS_S;
   end

   // result for special operands, in priority order NaN > inf > zero
   always_comb begin
      spec_result = {BUS_WIDTH{1'b0}};
      spec_nv     = 1'b0;
      if (nan1 || nan2 || inf_times_zero) begin
         spec_result = QNAN;
         spec_nv     = inf_times_zero;
      end else if (inf1 || inf2) begin
         spec_result = {sign1 ^ sign2, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
      end else begin
         spec_result = {sign1 ^ sign2, {(BUS_WIDTH-1){1'b0}}};
      end
   end

`ifdef FPMUL_FLAGS_EN
   // signalling NaN: NaN with the quiet bit clear
   always_comb begin
      snan1 = nan1 && !man1[MANTISSA_SIZE-1];
      snan2 = nan2 && !man2[MANTISSA_SIZE-1];
   end
`endif

   // normalise the product, round to nearest even, detect range errors
   always_comb begin
      prod_hi = acc_q[PW-1];
      mant    = acc_q[PW-2 -: MW];
      guard   = acc_q[MANTISSA_SIZE-1];
      sticky  = |acc_q[MANTISSA_SIZE-2:0];
      exp_n   = exp_q;
      if (prod_hi) begin
         // product in [2,4): drop one more bit and bump the exponent
         mant   = acc_q[PW-1 -: MW];
         guard  = acc_q[MANTISSA_SIZE];
         sticky = |acc_q[MANTISSA_SIZE-1:0];
         exp_n  = exp_q + ONE_S;
      end
      round_inc = guard && (sticky || mant[0]);
      rounded   = {1'b0, mant} + {{MW{1'b0}}, round_inc};
      frac      = rounded[MANTISSA_SIZE-1:0];
      exp_f     = exp_n;
      if (rounded[MW]) begin
         // rounding carried out of the significand: 1.111..1 -> 10.000..0
         frac  = rounded[MANTISSA_SIZE:1];
         exp_f = exp_n + ONE_S;
      end
      ovf = (exp_f >= EXP_MAX);
      unf = (exp_f <= ZERO_S);
      if (ovf) begin
         norm_result = {sign_q, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
      end else if (unf) begin
         norm_result = {sign_q, {(BUS_WIDTH-1){1'b0}}};
      end else begin
         norm_result = {sign_q, exp_f[EXPONENT_SIZE-1:0], frac};
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_valid) state_next = is_special ? DONE : MUL;
         MUL:  if (count_q == LAST_COUNT) state_next = NORM;
         NORM: state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // handshake outputs decoded from state
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // datapath: operand capture, shift-add multiply, result register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sign_q   <= 1'b0;
         exp_q    <= ZERO_S;
         mcand_q  <= {PW{1'b0}};
         acc_q    <= {PW{1'b0}};
         mplier_q <= {MW{1'b0}};
         count_q  <= {CW{1'b0}};
         out_q    <= {BUS_WIDTH{1'b0}};
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign_q   <= sign1 ^ sign2;
                  exp_q    <= exp_sum;
                  mcand_q  <= {{MW{1'b0}}, 1'b1, man1};
                  mplier_q <= {1'b1, man2};
                  acc_q    <= {PW{1'b0}};
                  count_q  <= {CW{1'b0}};
                  if (is_special) begin
                     out_q <= spec_result;
                  end
               end
            end
            MUL: begin
               // multiplier consumed LSB first; multiplicand walks left
               if (mplier_q[0]) begin
                  acc_q <= acc_q + mcand_q;
               end
               mcand_q  <= {mcand_q[PW-2:0], 1'b0};
               mplier_q <= {1'b0, mplier_q[MW-1:1]};
               count_q  <= count_q + CW'(1);
            end
            NORM: begin
               out_q <= norm_result;
            end
            default: begin
               // DONE: hold the result until it is taken
            end
         endcase
      end
   end

`ifdef FPMUL_FLAGS_EN
   // exception flags, produced alongside the result they describe
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fflags_q <= 5'b0;
      end else if (state == IDLE && in_valid) begin
         if (is_special) begin
            fflags_q <= {spec_nv || snan1 || snan2, 4'b0000};
         end
      end else if (state == NORM) begin
         fflags_q <= {1'b0, 1'b0, ovf, unf, guard || sticky || ovf || unf};
      end
   end

   assign fflags = fflags_q;
`endif

   assign out = out_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq (double precision): directed cases plus random operands
// checked against an arithmetic reference model and an expected-result queue.
module tb_fp_mul_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in1;
   logic [63:0] in2;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out;
`ifdef FPMUL_FLAGS_EN
   logic [4:0]  fflags;
`endif

   int errors = 0;
   int checks = 0;

   logic [63:0] exp_q[$];
   logic [4:0]  exp_f_q[$];
   int          lat_q[$];

   fp_mul_seq #(.BUS_WIDTH(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out)
`ifdef FPMUL_FLAGS_EN
      ,
      .fflags    (fflags)
`endif
   );

   // clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s: got=%h expected=%h", tag, got, expv);
      end
   endtask

   // reference model: exact integer product, rounding from the remainder
   function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] r, output logic [4:0] f,
                                 output bit spec);
      logic        s;
      logic [10:0] ea, eb;
      logic [51:0] ma, mb;
      bit          nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, snan_a, snan_b, ixz;
      logic [105:0] p, keep, rem, half;
      int          e, sh;
      bit          up, inexact;
      s  = a[63] ^ b[63];
      ea = a[62:52]; eb = b[62:52];
      ma = a[51:0];  mb = b[51:0];
      nan_a  = (ea == 11'h7ff) && (ma != 0);
      nan_b  = (eb == 11'h7ff) && (mb != 0);
      snan_a = nan_a && !ma[51];
      snan_b = nan_b && !mb[51];
      inf_a  = (ea == 11'h7ff) && (ma == 0);
      inf_b  = (eb == 11'h7ff) && (mb == 0);
      zero_a = (ea == 0);
      zero_b = (eb == 0);
      ixz    = (inf_a && zero_b) || (inf_b && zero_a);
      f = 5'b0;
      spec = 1'b1;
      r = 64'h0;
      if (nan_a || nan_b || ixz) begin
         r = 64'h7ff8000000000000;
         f[4] = ixz || snan_a || snan_b;
      end else if (inf_a || inf_b) begin
         r = {s, 11'h7ff, 52'h0};
      end else if (zero_a || zero_b) begin
         r = {s, 63'h0};
      end else begin
         spec = 1'b0;
         p = {53'h0, 1'b1, ma} * {53'h0, 1'b1, mb};
         e = int'(ea) + int'(eb) - 1023;
         if (p >= (106'd1 << 105)) begin
            sh = 53;
            e++;
         end else begin
            sh = 52;
         end
         keep = p >> sh;
         rem  = p - (keep << sh);
         half = 106'd1 << (sh - 1);
         inexact = (rem != 0);
         up = (rem > half) || ((rem == half) && keep[0]);
         keep = keep + 106'(up);
         if (keep == (106'd1 << 53)) begin
            keep = keep >> 1;
            e++;
         end
         if (e >= 2047) begin
            r = {s, 11'h7ff, 52'h0};
            f = 5'b00101;
         end else if (e <= 0) begin
            r = {s, 63'h0};
            f = 5'b00011;
         end else begin
            r = {s, 11'(e), keep[51:0]};
            f = {4'b0, inexact};
         end
      end
   endfunction

   // driver: present operands at a falling edge, accept on the next rising edge
   task automatic send(input logic [63:0] a, input logic [63:0] b, input bit push);
      logic [63:0] r;
      logic [4:0]  f;
      bit          spec;
      check("in_ready_before_send", {63'h0, in_ready}, 64'h1);
      model(a, b, r, f, spec);
      if (push) begin
         exp_q.push_back(r);
         exp_f_q.push_back(f);
         lat_q.push_back(spec ? 1 : 55);
      end
      in1 = a;
      in2 = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in1 = {$urandom, $urandom};
      in2 = {$urandom, $urandom};
   endtask

   // wait (bounded) for out_valid; lat starts at 1 = one rising edge since accept
   task automatic wait_result(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // scoreboard: compare the presented result against the queue head
   task automatic score(input string tag, input int lat);
      logic [63:0] r;
      logic [4:0]  f;
      int          el;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 64'h1, 64'h0);
         return;
      end
      r  = exp_q.pop_front();
      f  = exp_f_q.pop_front();
      el = lat_q.pop_front();
      check({tag, "_latency"}, 64'(lat), 64'(el));
      check({tag, "_out"}, out, r);
`ifdef FPMUL_FLAGS_EN
      check({tag, "_fflags"}, {59'h0, fflags}, {59'h0, f});
`else
      if (f === 5'bx) $display("unexpected X in model flags");
`endif
   endtask

   // full transaction with out_ready high
   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b);
      int lat;
      send(a, b, 1'b1);
      wait_result(lat);
      score(tag, lat);
      @(negedge clk);
      check({tag, "_valid_drop"}, {63'h0, out_valid}, 64'h0);
   endtask

   function automatic logic [63:0] rand_normal();
      logic [10:0] e;
      logic [51:0] m;
      int mode;
      mode = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) e = 11'($urandom_range(1, 2046));
      else e = 11'($urandom_range(900, 1150));
      m = {$urandom, $urandom};
      if (mode == 1) m = m & 52'hfff0000000000;     // sparse: exercises ties
      else if (mode == 2) m = m & 52'h00000000000ff;
      else if (mode == 3) m = 52'hfffffffffffff;    // carry out of rounding
      return {1'($urandom_range(0, 1)), e, m};
   endfunction

   initial begin
      logic [63:0] specials[6];
      logic [63:0] held;
      int          lat;
      bit          seen;
      specials[0] = 64'h0000000000000000;
      specials[1] = 64'h8000000000000000;
      specials[2] = 64'h7ff0000000000000;
      specials[3] = 64'h7ff8000000000000;
      specials[4] = 64'h7ff0000000000001;
      specials[5] = 64'h000000000000abcd;

      // reset
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      in1 = 64'h0;
      in2 = 64'h0;
      repeat (3) @(negedge clk);
      check("reset_in_ready", {63'h0, in_ready}, 64'h1);
      check("reset_out_valid", {63'h0, out_valid}, 64'h0);
      check("reset_out", out, 64'h0);
`ifdef FPMUL_FLAGS_EN
      check("reset_fflags", {59'h0, fflags}, 64'h0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // directed values
      run_op("two_times_three", 64'h4000000000000000, 64'h4008000000000000);
      check("two_times_three_const", exp_q.size() == 0 ? 64'h0 : 64'h1, 64'h0);
      run_op("neg_1p5_sq", 64'h3ff8000000000000, 64'hbff8000000000000);
      run_op("rne_sticky_down", 64'h3ff0000000000001, 64'h3ff0000000000001);
      run_op("inf_times_zero", 64'h7ff0000000000000, 64'h0000000000000000);
      run_op("overflow", 64'h7fe0000000000000, 64'h4000000000000000);
      run_op("underflow", 64'h0010000000000000, 64'h0010000000000000);
      run_op("subnormal_flush", 64'h8000000000000001, 64'h3ff0000000000000);
      run_op("snan_input", 64'h7ff0000000000001, 64'h3ff0000000000000);
      run_op("qnan_input", 64'h4000000000000000, 64'h7ff8000000000000);
      run_op("neg_inf", 64'hfff0000000000000, 64'h4000000000000000);
      run_op("round_carry", 64'h3fffffffffffffff, 64'h3fffffffffffffff);

      // backpressure: result held while out_ready is low, new inputs ignored
      out_ready = 1'b0;
      send(64'h3ff8000000000000, 64'hbff8000000000000, 1'b1);
      wait_result(lat);
      held = out;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in1 = rand_normal();
         in2 = rand_normal();
         @(negedge clk);
         check("hold_out", out, held);
         check("hold_valid", {63'h0, out_valid}, 64'h1);
         check("hold_in_ready", {63'h0, in_ready}, 64'h0);
      end
      score("held_result", lat);
      in1 = 64'h4000000000000000;
      in2 = 64'h4008000000000000;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("post_hs_valid", {63'h0, out_valid}, 64'h0);
      check("post_hs_in_ready", {63'h0, in_ready}, 64'h1);
      send(64'h4000000000000000, 64'h4008000000000000, 1'b1);
      wait_result(lat);
      score("after_backpressure", lat);
      @(negedge clk);

      // reset in the middle of a multiply aborts it
      send(64'h4000000000000000, 64'h4008000000000000, 1'b0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_in_ready", {63'h0, in_ready}, 64'h1);
      check("abort_out_valid", {63'h0, out_valid}, 64'h0);
      check("abort_out", out, 64'h0);
      seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("abort_no_stale", {63'h0, seen}, 64'h0);
      run_op("after_abort", 64'h4000000000000000, 64'h4008000000000000);

      // random operands
      for (int i = 0; i < 40; i++) begin
         logic [63:0] a;
         logic [63:0] b;
         a = rand_normal();
         b = rand_normal();
         if ($urandom_range(0, 5) == 0) b = specials[$urandom_range(0, 5)];
         run_op("random", a, b);
      end

      check("queue_drained", 64'(exp_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
